// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment digit scanner.
// Scan FSM states, nibble type and digit-enable polarity helper.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    SCAN,
    PENDING
  } scan_state_t;

  typedef logic [3:0] nibble_t;

  // Map a logical "digit lit" onto the panel's anode level.
  function automatic logic en_level(
    input logic on,
    input logic active_low
  );
    return active_low ? ~on : on;
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1, tick on the last count.
// Synchronous clear holds the count at zero while the display is idle.
module seven_seg_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(PRESCALE);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(PRESCALE - 1));

  // Free-running slot counter with wrap and synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_digit_scanner.sv
// Time-multiplexed hex digit scanner feeding a seven-segment decoder.
// Optional leading-zero blanking: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_digit_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [3:0]              scan_hex,
  output logic                    scan_dp,
  output logic                    scan_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  scan_state_t state, state_n;

  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [4*NUM_DIGITS-1:0] shad_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   shad_dp_q;

  logic accept;
  logic tick;
  logic live;
  logic frame_int;
  logic load_disp;
  logic load_shad;
  logic commit;
  logic lz_blank;

  nibble_t               cur_hex;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] en_n;
  logic [NUM_DIGITS-1:0] en_idle;

  assign in_ready  = (state != PENDING);
  assign accept    = in_valid && in_ready;
  assign live      = (state != EMPTY);
  assign frame_int = tick && (idx == LAST);

  seven_seg_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clear(state == EMPTY),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next state and load strobes.
  always_comb begin
    state_n   = state;
    load_disp = 1'b0;
    load_shad = 1'b0;
    commit    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_n   = SCAN;
          load_disp = 1'b1;
        end
      end
      SCAN: begin
        if (accept) begin
          state_n   = PENDING;
          load_shad = 1'b1;
        end
      end
      PENDING: begin
        if (frame_int) begin
          state_n = SCAN;
          commit  = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Digit index advances once per slot, parked at 0 when idle.
  always_ff @(posedge clk) begin
    if (!reset || state == EMPTY) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == LAST) ? '0 : idx + IW'(1);
    end
  end

  // Display registers: direct load when idle, shadow copy at frame end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_q <= '0;
      dp_q   <= '0;
    end else if (load_disp) begin
      disp_q <= in_value;
      dp_q   <= in_dp;
    end else if (commit) begin
      disp_q <= shad_q;
      dp_q   <= shad_dp_q;
    end
  end

  // Shadow holds a value accepted mid-frame until the frame ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shad_q    <= '0;
      shad_dp_q <= '0;
    end else if (load_shad) begin
      shad_q    <= in_value;
      shad_dp_q <= in_dp;
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [IW-1:0]           msd_n;
  logic [IW-1:0]           msd_q;

  assign load_val = load_disp ? in_value : shad_q;

  // Most significant nonzero digit of the value about to be shown.
  always_comb begin
    msd_n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] != 4'h0) begin
        msd_n = IW'(i);
      end
    end
  end

  // MSD index is latched alongside the display registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      msd_q <= '0;
    end else if (load_disp || commit) begin
      msd_q <= msd_n;
    end
  end

  assign lz_blank = (idx > msd_q);
`else
  assign lz_blank = 1'b0;
`endif

  // Select the nibble, dp and anode pattern for the current slot.
  always_comb begin
    cur_hex = '0;
    cur_dp  = 1'b0;
    en_n    = '0;
    en_idle = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_hex = disp_q[4*i +: 4];
        cur_dp  = dp_q[i];
      end
      en_n[i]    = en_level(live && !lz_blank && idx == IW'(i),
                            ANODE_ACTIVE_LOW);
      en_idle[i] = en_level(1'b0, ANODE_ACTIVE_LOW);
    end
  end

  // Registered panel outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_hex   <= '0;
      scan_dp    <= 1'b0;
      scan_blank <= 1'b1;
      digit_en   <= en_idle;
      frame_done <= 1'b0;
    end else begin
      scan_hex   <= live ? cur_hex : 4'h0;
      scan_dp    <= live ? cur_dp : 1'b0;
      scan_blank <= !live || lz_blank;
      digit_en   <= en_n;
      frame_done <= live && frame_int;
    end
  end

endmodule
